dma_axi_r: RTL

DMA_AXI_R -- requirements
Module: dma_axi_r

---
 rtl/dma_axi_r.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dma_axi_r.sv
// dma_axi_r: AXI4 read-burst master for a simple DMA databus.
//   A databus request (valid, addr, dma_len) is issued as one INCR burst on the
//   AR channel, and each accepted R beat is handed back on rdata with a ready
//   strobe. At most one burst is outstanding. dma_ready reports idle, error is
//   sticky over a burst (any non-OKAY rresp).
//   Ports: clk, rst (sync, active-high); databus valid/addr/dma_len in,
//   ready/rdata/dma_ready/error out; AXI AR channel out (arready in);
//   AXI R channel in (rready out).
//   Optional: define DMA_AXI_R_RLAST_CHK_EN to also flag beats whose rlast
//   disagrees with the expected final beat.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_LOCK_W
`define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
`define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
`define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
`define AXI_QOS_W 4
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module dma_axi_r #(
    parameter int DMA_DATA_W = 32,
    parameter int ADDR_W     = `AXI_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     ready,
    output logic [DMA_DATA_W-1:0]    rdata,
    input  logic [`AXI_LEN_W-1:0]    dma_len,
    output logic                     dma_ready,
    output logic                     error,
    output logic [`AXI_ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic [`AXI_LEN_W-1:0]    m_axi_arlen,
    output logic [`AXI_SIZE_W-1:0]   m_axi_arsize,
    output logic [`AXI_BURST_W-1:0]  m_axi_arburst,
    output logic [`AXI_LOCK_W-1:0]   m_axi_arlock,
    output logic [`AXI_CACHE_W-1:0]  m_axi_arcache,
    output logic [`AXI_PROT_W-1:0]   m_axi_arprot,
    output logic [`AXI_QOS_W-1:0]    m_axi_arqos,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DMA_DATA_W-1:0]    m_axi_rdata,
    input  logic [`AXI_RESP_W-1:0]   m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);
    localparam int SIZE = $clog2(DMA_DATA_W / 8);

    typedef enum logic [1:0] {R_ADDR_HS = 2'd0, R_DATA = 2'd1} state_t;

    state_t                state, state_nx;
    logic [`AXI_LEN_W:0]   cnt;
    logic [`AXI_LEN_W-1:0] len_r;
    logic                  err_r, rdy_r, last, beat_err;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = dma_len;
    assign m_axi_arsize  = `AXI_SIZE_W'(SIZE);
    assign m_axi_arburst = `AXI_BURST_W'(1);
    assign m_axi_arlock  = '0;
    assign m_axi_arcache = `AXI_CACHE_W'(2);
    assign m_axi_arprot  = `AXI_PROT_W'(2);
    assign m_axi_arqos   = '0;
    assign rdata         = m_axi_rdata;
    assign dma_ready     = rdy_r;
    assign error         = err_r;

    // len_r is latched at the AR handshake so mid-burst dma_len changes are inert
    assign last = cnt == {1'b0, len_r};
`ifdef DMA_AXI_R_RLAST_CHK_EN
    assign beat_err = (m_axi_rresp != '0) || (m_axi_rlast != last);
`else
    logic rlast_unused;
    assign rlast_unused = m_axi_rlast;
    assign beat_err = m_axi_rresp != '0;
`endif

    always_comb begin
        state_nx      = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        ready         = 1'b0;
        case (state)
            R_ADDR_HS: begin
                m_axi_arvalid = valid;
                state_nx      = (valid && m_axi_arready) ? R_DATA : R_ADDR_HS;
            end
            R_DATA: begin
                m_axi_rready = 1'b1;
                ready        = m_axi_rvalid;
                state_nx     = (m_axi_rvalid && last) ? R_ADDR_HS : R_DATA;
            end
            default: state_nx = R_ADDR_HS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= R_ADDR_HS;
            cnt   <= '0;
            len_r <= '0;
            err_r <= 1'b0;
            rdy_r <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == R_ADDR_HS) begin
                rdy_r <= !valid;
                if (valid && m_axi_arready) begin
                    cnt   <= '0;
                    len_r <= dma_len;
                    err_r <= 1'b0;
                end
            end else begin
                rdy_r <= 1'b0;
                if (ready) begin
                    cnt <= cnt + 1'b1;
                    if (beat_err)
                        err_r <= 1'b1;
                end
            end
        end
    end
endmodule
